// File: rtl/hazard_forward_unit.sv
// Load-use stall and EX operand forwarding for a classic 5-stage pipeline.
// Tracks {valid, dest, is_load} for the EX, MEM and WB stages.
module hazard_forward_unit #(
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [2:0]          irj,
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    input  logic                id_reg_write,
    input  logic                id_is_load,
    input  logic                id_src_rt,
    input  logic                id_link,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [REG_BITS-1:0] ex_dest
);

    localparam logic [2:0]          IRJ_I    = 3'b100;
    localparam logic [2:0]          IRJ_R    = 3'b010;
    localparam logic [2:0]          IRJ_J    = 3'b001;
    localparam logic [REG_BITS-1:0] LINK_REG = REG_BITS'(31);

    typedef struct packed {
        logic                valid;
        logic                is_load;
        logic [REG_BITS-1:0] dest;
    } slot_t;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_e;

    slot_t     r_ex, r_mem, r_wb;
    fwd_sel_e  r_fwd_a, r_fwd_b;

    logic [REG_BITS-1:0] w_src_a, w_src_b, w_dest;
    logic                w_stall, w_issue;
    fwd_sel_e            w_fwd_a, w_fwd_b;
    slot_t               w_id_slot;

    // Register 0 never matches: a zero source or zero destination is "absent".
    function automatic logic hits(input slot_t s, input logic [REG_BITS-1:0] src);
        return s.valid && (src != '0) && (s.dest == src);
    endfunction

    function automatic fwd_sel_e fwd_sel(input slot_t ex, input slot_t mem,
                                         input logic [REG_BITS-1:0] src);
        if (hits(ex, src) && !ex.is_load) return FWD_EX_MEM;
        else if (hits(mem, src))          return FWD_MEM_WB;
        else                              return FWD_RF;
    endfunction

    // NOTE: every output of a combinational block gets a default up front so no latch is inferred.
    always_comb begin
        w_src_a = '0;
        w_src_b = '0;
        w_dest  = '0;
        case (irj)
            IRJ_R: begin
                w_src_a = rs;
                w_src_b = rt;
                if (id_reg_write) w_dest = rd;
            end
            IRJ_I: begin
                w_src_a = rs;
                if (id_src_rt)    w_src_b = rt;
                if (id_reg_write) w_dest  = rt;
            end
            IRJ_J: begin
                if (id_reg_write && id_link) w_dest = LINK_REG;
            end
            default: ;  // non-one-hot: no sources, no destination
        endcase
    end

    assign w_stall = id_valid && !flush && r_ex.valid && r_ex.is_load &&
                     (hits(r_ex, w_src_a) || hits(r_ex, w_src_b));
    assign w_issue = id_valid && !w_stall && !flush;

    assign w_id_slot = '{valid: 1'b1, is_load: id_is_load, dest: w_dest};
    assign w_fwd_a   = fwd_sel(r_ex, r_mem, w_src_a);
    assign w_fwd_b   = fwd_sel(r_ex, r_mem, w_src_b);

    // NOTE: state is updated with non-blocking assignments so all slots shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex    <= w_id_slot;
                r_fwd_a <= w_fwd_a;
                r_fwd_b <= w_fwd_b;
            end else begin
                r_ex    <= '0;
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end
        end
    end

    assign stall   = w_stall;
    assign fwd_a   = r_fwd_a;
    assign fwd_b   = r_fwd_b;
    assign ex_dest = r_ex.dest;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard unit sitting directly downstream of `instruction_property` in the ID stage. It consumes the decoded type (`irj`) and register fields (`rs`, `rt`, `rd`) of the instruction in ID. It keeps a 3-slot shadow of destination registers for the EX, MEM and WB stages. From that shadow it produces a combinational load-use stall for ID, and registered forwarding selects for the two ALU operands of the instruction in EX.

## Interface
Parameters:
- `REG_BITS`, 5: register index width.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `irj`  in  3  one-hot type from `instruction_property`: 3'b100 I, 3'b010 R, 3'b001 J.
- `rs`, `rt`, `rd`  in  REG_BITS each  register fields from `instruction_property`.
- `id_reg_write`  in  1  ID instruction writes the register file.
- `id_is_load`  in  1  ID instruction is a load.
- `id_src_rt`  in  1  I-type instruction also reads `rt` (stores, branches).
- `id_link`  in  1  J-type instruction writes register 31 (jal).
- `flush`  in  1  branch/jump taken; squash the ID instruction.
- `stall`  out  1  hold PC and IF/ID; insert a bubble into EX.
- `fwd_a`, `fwd_b`  out  2  operand select for the EX instruction: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- `ex_dest`  out  REG_BITS  destination register of the EX slot (0 if none).

## Operation
- Per ID instruction, the block computes two sources and one destination:
  - Sources:
    - R: `rs` and `rt`.
    - I: `rs`, plus `rt` when `id_src_rt`.
    - J: none.
  - Destination, only when `id_reg_write`:
    - R: `rd`.
    - I: `rt`.
    - J: 31 when `id_link`, else none.
- A source or destination equal to register 0 is treated as absent. It never hazards and never forwards.
- An `irj` that is not one-hot is treated as J-type: no sources, no destination.
- Each slot (EX, MEM, WB) holds {valid, dest, is_load}.
- stall = `id_valid` and EX.valid and EX.is_load and EX.dest is nonzero and EX.dest equals an ID source.
  - `stall` is combinational.
  - `stall` is forced to 0 when `flush` is high.
- Every rising edge:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes the ID entry when `id_valid` and not `stall` and not `flush`. Otherwise EX takes a bubble (valid 0, dest 0).
- `fwd_a`/`fwd_b` are registered on the same edge that loads EX, from the ID `rs` and the effective `rt`:
  - 10 when current EX.valid and EX.dest matches the source.
  - Else 01 when current MEM.valid and MEM.dest matches.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
  - A bubble loaded into EX loads 00/00.
  - An absent source gives 00.
- Never generated: EX/MEM forwarding from a load. The stall guarantees a dependent instruction sees the load only from MEM/WB.
- Not handled here: a WB-stage dependency against ID. The register file writes before it reads.

## Timing
- Reset (`rst_n` low, asynchronous): all slots invalid with dest 0; `fwd_a` = `fwd_b` = 00; `ex_dest` = 0; `stall` = 0.
- Reset asserted mid-operation clears everything immediately. The first edge after release loads EX normally.
- Load-use costs exactly one stall cycle:
  - Cycle n: load in EX, stall = 1.
  - Cycle n+1: load in MEM, bubble in EX, stall = 0.
  - Cycle n+2: dependent instruction in EX with select 01.
- Back-to-back ALU dependency: zero stalls, select 10 in the cycle the dependent instruction is in EX.
- `flush` together with a stall condition: flush wins; a bubble enters EX and stall = 0.
- Slots always shift, even during a stall. No freeze input exists.

## Test plan
- Reset: hold `rst_n` low mid-stream with the pipeline full -> `stall` = 0, `fwd_a` = `fwd_b` = 00, `ex_dest` = 0 immediately. First instruction after release behaves as if the pipeline was empty.
- ALU chain: addi $t1,$t2,9 (0x21490009, I, rs=10, rt=9, write) then add $t0,$t1,$t2 (0x012A4020) -> no stall; for the add in EX, `fwd_a` = 10 and `fwd_b` = 00. `ex_dest` = 9, then 8.
- Distance two: the addi, an independent add $s0,$s1,$s2, then add $t0,$t1,$t2 -> third instruction in EX has `fwd_a` = 01.
- Load-use: lw $t1,0($t2) (`id_is_load`, dest 9) then add $t0,$t1,$t2 -> `stall` = 1 for exactly one cycle, bubble in EX. The add reaches EX two cycles after the lw with `fwd_a` = 01.
- Register 0 and J-type: addi $zero,$t2,1 then add $t0,$zero,$zero -> no stall, 00/00. j 0x02FFFFF (0x082FFFFF) with `id_link` = 0 -> EX dest 0.
- Flush during stall: the lw/add stall case with `flush` = 1 in the stall cycle -> `stall` = 0, bubble enters EX, selects 00/00.
